// File: rtl/regex_cpu_pipelined_pkg.sv
// Shared types for the pipelined regex CPU: opcode encoding and execute-stage state.
package regex_cpu_pipelined_pkg;

  localparam int OPCODE_WIDTH = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_MATCH                 = 3'd0,
    OP_NOT_MATCH             = 3'd1,
    OP_MATCH_ANY             = 3'd2,
    OP_JMP                   = 3'd3,
    OP_SPLIT                 = 3'd4,
    OP_ACCEPT                = 3'd5,
    OP_ACCEPT_PARTIAL        = 3'd6,
    OP_END_WITHOUT_ACCEPTING = 3'd7
  } opcode_e;

  typedef enum logic {
    EX_FIRST        = 1'b0,
    EX_SPLIT_SECOND = 1'b1
  } exec_state_e;

  // Operand field width left after the opcode is peeled off the instruction word.
  function automatic int instruction_data_width(input int memory_width);
    return memory_width - OPCODE_WIDTH;
  endfunction

endpackage

// File: rtl/regex_cpu_pipelined_if.sv
// Thread-in, program-fetch, thread-out and status signals of the pipelined regex CPU.
// slave = the CPU itself, master = scheduler / memory arbiter side.
interface regex_cpu_pipelined_if #(
  parameter int PC_WIDTH          = 9,
  parameter int CC_ID_BITS        = 2,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0] current_characters;
  logic [2**CC_ID_BITS-1:0]                   end_of_string;

  logic                         input_pc_valid;
  logic                         input_pc_ready;
  logic [PC_WIDTH-1:0]          input_pc;
  logic [CC_ID_BITS-1:0]        input_cc_id;

  logic                         memory_valid;
  logic                         memory_ready;
  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr;
  logic [MEMORY_WIDTH-1:0]      memory_data;

  logic                         output_pc_valid;
  logic                         output_pc_ready;
  logic [PC_WIDTH-1:0]          output_pc;
  logic [CC_ID_BITS-1:0]        output_cc_id;

  logic                         accepts;
  logic [CC_ID_BITS-1:0]        accepts_cc_id;
  logic                         busy;

  modport slave (
    input  current_characters, end_of_string,
    input  input_pc_valid, input_pc, input_cc_id,
    output input_pc_ready,
    output memory_valid, memory_addr,
    input  memory_ready, memory_data,
    output output_pc_valid, output_pc, output_cc_id,
    input  output_pc_ready,
    output accepts, accepts_cc_id, busy
  );

  modport master (
    output current_characters, end_of_string,
    output input_pc_valid, input_pc, input_cc_id,
    input  input_pc_ready,
    input  memory_valid, memory_addr,
    output memory_ready, memory_data,
    input  output_pc_valid, output_pc, output_cc_id,
    output output_pc_ready,
    input  accepts, accepts_cc_id, busy
  );
endinterface

// File: rtl/regex_cpu_pipelined_fifo.sv
// Small synchronous FIFO used for the in-order tag and instruction return queues.
module regex_cpu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/regex_cpu_pipelined.sv
// Pipelined regex CPU: fetch register -> memory -> in-order return queues -> execute -> output register.
// Credits bound the number of threads between input handshake and retirement to MAX_INFLIGHT.
//
//   state           | meaning
//   EX_FIRST        | executing a fresh head instruction (or first half of a SPLIT)
//   EX_SPLIT_SECOND | SPLIT first successor issued, second (jump target) still owed
module regex_cpu_pipelined
  import regex_cpu_pipelined_pkg::*;
#(
  parameter int PC_WIDTH          = 9,
  parameter int CC_ID_BITS        = 2,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEM_LATENCY       = 1,
  parameter int MAX_INFLIGHT      = 4
) (
  input logic                  clk,
  input logic                  rst,
  regex_cpu_pipelined_if.slave bus
);
  localparam int INSTRUCTION_DATA_WIDTH = instruction_data_width(MEMORY_WIDTH);
  localparam int COUNT_WIDTH            = $clog2(MAX_INFLIGHT) + 1;
  localparam int TAG_WIDTH              = PC_WIDTH + CC_ID_BITS;

  logic                              input_hs, memory_hs, output_hs;
  logic                              req_pending;
  logic [PC_WIDTH-1:0]               req_pc;
  logic [CC_ID_BITS-1:0]             req_cc_id;
  logic [MEM_LATENCY-1:0]            data_valid_dly;
  logic [COUNT_WIDTH-1:0]            credit_count;

  logic [TAG_WIDTH-1:0]              tag_head;
  logic                              tag_full, tag_empty, data_full, data_empty;
  logic [MEMORY_WIDTH-1:0]           head_word;
  logic                              head_valid;
  logic [PC_WIDTH-1:0]               head_pc;
  logic [CC_ID_BITS-1:0]             head_cc;
  opcode_e                           opcode;
  logic [INSTRUCTION_DATA_WIDTH-1:0] instr_data;
  logic [CHARACTER_WIDTH-1:0]        head_char;
  logic                              head_eos;

  exec_state_e                       exec_state, exec_state_next;
  logic                              out_free, want_emit, accept_cond;
  logic                              exec_emit, exec_pop, exec_accept;
  logic [PC_WIDTH-1:0]               emit_pc;
  logic [CC_ID_BITS-1:0]             emit_cc;
  logic                              emit_last;
  logic                              retire_out, retire_exec;

  logic                              out_valid, out_last;
  logic [PC_WIDTH-1:0]               out_pc;
  logic [CC_ID_BITS-1:0]             out_cc;
  logic                              accepts_q;
  logic [CC_ID_BITS-1:0]             accepts_cc_q;
  logic                              unused_ok;

  assign bus.input_pc_ready = !rst && (credit_count < COUNT_WIDTH'(MAX_INFLIGHT))
                              && (!req_pending || bus.memory_ready);
  assign input_hs  = bus.input_pc_valid && bus.input_pc_ready;
  assign memory_hs = req_pending && bus.memory_ready;
  assign output_hs = out_valid && bus.output_pc_ready;

  assign bus.memory_valid = req_pending;
  assign bus.memory_addr  = MEMORY_ADDR_WIDTH'(req_pc);

  // Fetch register: holds one request stable until memory takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pending <= 1'b0;
      req_pc      <= '0;
      req_cc_id   <= '0;
    end else if (input_hs) begin
      req_pending <= 1'b1;
      req_pc      <= bus.input_pc;
      req_cc_id   <= bus.input_cc_id;
    end else if (memory_hs) begin
      req_pending <= 1'b0;
    end
  end

  // Valid delay line marks the cycle memory_data belongs to an accepted fetch; cleared data is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid_dly <= '0;
    end else begin
      data_valid_dly[0] <= memory_hs;
      for (int i = 1; i < MEM_LATENCY; i++) data_valid_dly[i] <= data_valid_dly[i-1];
    end
  end

  regex_cpu_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk(clk), .rst(rst),
    .push(memory_hs), .push_data({req_pc, req_cc_id}),
    .pop(exec_pop), .pop_data(tag_head),
    .full(tag_full), .empty(tag_empty)
  );

  regex_cpu_fifo #(.WIDTH(MEMORY_WIDTH), .DEPTH(MAX_INFLIGHT)) u_data_fifo (
    .clk(clk), .rst(rst),
    .push(data_valid_dly[MEM_LATENCY-1]), .push_data(bus.memory_data),
    .pop(exec_pop), .pop_data(head_word),
    .full(data_full), .empty(data_empty)
  );

  assign head_valid = !tag_empty && !data_empty;
  assign head_pc    = tag_head[TAG_WIDTH-1 -: PC_WIDTH];
  assign head_cc    = tag_head[CC_ID_BITS-1:0];
  assign opcode     = opcode_e'(head_word[MEMORY_WIDTH-1 -: OPCODE_WIDTH]);
  assign instr_data = head_word[INSTRUCTION_DATA_WIDTH-1:0];
  assign head_char  = bus.current_characters[head_cc*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  assign head_eos   = bus.end_of_string[head_cc];
  assign out_free   = !out_valid || bus.output_pc_ready;
  assign unused_ok  = ^{instr_data, tag_full, data_full};

  // Execute state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exec_state <= EX_FIRST;
    else     exec_state <= exec_state_next;
  end

  // Next state: a SPLIT toggles between its two issues whenever the output register can take one.
  always_comb begin
    exec_state_next = exec_state;
    if (head_valid && opcode == OP_SPLIT && out_free)
      exec_state_next = (exec_state == EX_FIRST) ? EX_SPLIT_SECOND : EX_FIRST;
  end

  // Decode/execute outputs; drops and accepts retire without waiting on the output register.
  always_comb begin
    want_emit   = 1'b0;
    accept_cond = 1'b0;
    emit_pc     = head_pc + 1'b1;
    emit_cc     = head_cc;
    emit_last   = 1'b1;
    case (opcode)
      OP_MATCH: begin
        want_emit = !head_eos && (head_char == instr_data[CHARACTER_WIDTH-1:0]);
        emit_cc   = head_cc + 1'b1;
      end
      OP_NOT_MATCH: want_emit = !head_eos && (head_char != instr_data[CHARACTER_WIDTH-1:0]);
      OP_MATCH_ANY: begin
        want_emit = !head_eos;
        emit_cc   = head_cc + 1'b1;
      end
      OP_JMP: begin
        want_emit = 1'b1;
        emit_pc   = instr_data[PC_WIDTH-1:0];
      end
      OP_SPLIT: begin
        want_emit = 1'b1;
        if (exec_state == EX_SPLIT_SECOND) emit_pc = instr_data[PC_WIDTH-1:0];
        else                               emit_last = 1'b0;
      end
      OP_ACCEPT:         accept_cond = head_eos;
      OP_ACCEPT_PARTIAL: accept_cond = 1'b1;
      default: ;
    endcase
    exec_emit   = head_valid && want_emit && out_free;
    exec_pop    = head_valid && (want_emit ? (out_free && emit_last) : 1'b1);
    exec_accept = head_valid && accept_cond;
  end

  assign retire_out  = output_hs && out_last;
  assign retire_exec = exec_pop && !want_emit;

  // Credit counter: +1 per accepted thread, -1 per retirement path active this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) credit_count <= '0;
    else     credit_count <= credit_count + COUNT_WIDTH'(input_hs)
                             - COUNT_WIDTH'(retire_out) - COUNT_WIDTH'(retire_exec);
  end

  // Output register and accept pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_cc       <= '0;
      out_last     <= 1'b0;
      accepts_q    <= 1'b0;
      accepts_cc_q <= '0;
    end else begin
      if (exec_emit) begin
        out_valid <= 1'b1;
        out_pc    <= emit_pc;
        out_cc    <= emit_cc;
        out_last  <= emit_last;
      end else if (bus.output_pc_ready) begin
        out_valid <= 1'b0;
      end
      accepts_q <= exec_accept;
      if (exec_accept) accepts_cc_q <= head_cc;
    end
  end

  assign bus.output_pc_valid = out_valid;
  assign bus.output_pc       = out_pc;
  assign bus.output_cc_id    = out_cc;
  assign bus.accepts         = accepts_q;
  assign bus.accepts_cc_id   = accepts_cc_q;
  assign bus.busy            = (credit_count != '0) || out_valid;
endmodule

// File: tb/tb_regex_cpu_pipelined.sv
// Directed bench: one DUT at MEM_LATENCY=1 drives most scenarios, a MEM_LATENCY=3 twin
// mirrors the back-to-back scenario to confirm ordering at longer latency.
module tb_regex_cpu_pipelined;
  import regex_cpu_pipelined_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_enable = 1'b0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  regex_cpu_pipelined_if bus_a ();
  regex_cpu_pipelined_if bus_b ();

  regex_cpu_pipelined #(.MEM_LATENCY(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  regex_cpu_pipelined #(.MEM_LATENCY(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.current_characters = bus_a.current_characters;
  assign bus_b.end_of_string      = bus_a.end_of_string;
  assign bus_b.input_pc_valid     = bus_a.input_pc_valid && b_enable;
  assign bus_b.input_pc           = bus_a.input_pc;
  assign bus_b.input_cc_id        = bus_a.input_cc_id;
  assign bus_b.memory_ready       = bus_a.memory_ready;
  assign bus_b.output_pc_ready    = bus_a.output_pc_ready;

  // Program memory models
  logic [15:0] prog [512];
  logic [15:0] mem_a_q;
  logic [15:0] mem_b_q [3];

  always @(posedge clk)
    if (bus_a.memory_valid && bus_a.memory_ready) mem_a_q <= prog[bus_a.memory_addr[8:0]];
  assign bus_a.memory_data = mem_a_q;

  always @(posedge clk) begin
    if (bus_b.memory_valid && bus_b.memory_ready) mem_b_q[0] <= prog[bus_b.memory_addr[8:0]];
    mem_b_q[1] <= mem_b_q[0];
    mem_b_q[2] <= mem_b_q[1];
  end
  assign bus_b.memory_data = mem_b_q[2];

  function automatic logic [15:0] enc(input opcode_e op, input logic [12:0] d);
    return {op, d};
  endfunction

  task automatic set_char(input int w, input logic [7:0] c);
    bus_a.current_characters[w*8 +: 8] = c;
  endtask

  // Offer one thread at a negedge, return at the negedge after its handshake.
  task automatic send(input logic [8:0] pc, input logic [1:0] cc);
    int n = 0;
    bus_a.input_pc_valid = 1'b1;
    bus_a.input_pc      = pc;
    bus_a.input_cc_id   = cc;
    while (!bus_a.input_pc_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL send_timeout: input_pc_ready stayed %0b, need 1", bus_a.input_pc_ready);
    end
    @(negedge clk);
    bus_a.input_pc_valid = 1'b0;
  endtask

  // Counts negedges (starting at 1 = first cycle after the input handshake) until output_pc_valid.
  task automatic wait_out_valid(output int n);
    n = 1;
    while (!bus_a.output_pc_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pop_output();
    bus_a.output_pc_ready = 1'b1;
    @(negedge clk);
    bus_a.output_pc_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_compared++;
    if ({bus_a.input_pc_ready, bus_a.memory_valid, bus_a.memory_addr, bus_a.output_pc_valid,
         bus_a.output_pc, bus_a.output_cc_id, bus_a.accepts, bus_a.accepts_cc_id, bus_a.busy} !== '0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: ready=%0b mvalid=%0b addr=%h ovalid=%0b busy=%0b, need all 0",
               bus_a.input_pc_ready, bus_a.memory_valid, bus_a.memory_addr, bus_a.output_pc_valid, bus_a.busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_compared++;
    if (bus_a.input_pc_ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_release_ready: got %0b, need 1", bus_a.input_pc_ready);
    end
  endtask

  task automatic test_match();
    int lat;
    bit seen;
    prog[9'h062] = enc(OP_MATCH, 13'h61);
    set_char(1, 8'h61);
    send(9'h062, 2'd1);
    wait_out_valid(lat);
    n_compared++;
    if (lat != 4) begin
      n_mismatched++;
      $display("FAIL match_latency: got %0d cycles, need 4", lat);
    end
    n_compared++;
    if (bus_a.output_pc !== 9'h063 || bus_a.output_cc_id !== 2'd2) begin
      n_mismatched++;
      $display("FAIL match_out: got pc=%h cc=%0d, need pc=063 cc=2", bus_a.output_pc, bus_a.output_cc_id);
    end
    pop_output();
    n_compared++;
    if (bus_a.busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL match_busy_after: got %0b, need 0", bus_a.busy);
    end
    // mismatch -> dropped
    set_char(1, 8'h62);
    send(9'h062, 2'd1);
    seen = 0;
    repeat (8) begin
      if (bus_a.output_pc_valid) seen = 1;
      @(negedge clk);
    end
    n_compared++;
    if (seen || bus_a.busy !== 1'b0 || bus_a.input_pc_ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL match_drop: out_seen=%0b busy=%0b ready=%0b, need 0 0 1", seen, bus_a.busy, bus_a.input_pc_ready);
    end
    // memory back-pressure holds the request stable
    set_char(1, 8'h61);
    bus_a.memory_ready = 1'b0;
    send(9'h062, 2'd1);
    repeat (3) @(negedge clk);
    n_compared++;
    if (bus_a.memory_valid !== 1'b1 || bus_a.memory_addr !== 11'h062 || bus_a.input_pc_ready !== 1'b0) begin
      n_mismatched++;
      $display("FAIL mem_stall_hold: mvalid=%0b addr=%h ready=%0b, need 1 062 0",
               bus_a.memory_valid, bus_a.memory_addr, bus_a.input_pc_ready);
    end
    bus_a.memory_ready = 1'b1;
    wait_out_valid(lat);
    n_compared++;
    if (bus_a.output_pc_valid !== 1'b1 || bus_a.output_pc !== 9'h063 || bus_a.output_cc_id !== 2'd2) begin
      n_mismatched++;
      $display("FAIL mem_stall_out: valid=%0b pc=%h cc=%0d, need 1 063 2",
               bus_a.output_pc_valid, bus_a.output_pc, bus_a.output_cc_id);
    end
    pop_output();
  endtask

  task automatic test_not_match();
    int lat;
    bit seen;
    logic [7:0] chs [4] = '{8'h62, 8'h6D, 8'h7A, 8'h71};
    prog[9'h010] = enc(OP_NOT_MATCH, 13'h61);
    for (int w = 0; w < 4; w++) set_char(w, chs[w]);
    for (int w = 0; w < 4; w++) begin
      send(9'h010, 2'(w));
      wait_out_valid(lat);
      n_compared++;
      if (bus_a.output_pc_valid !== 1'b1 || bus_a.output_pc !== 9'h011 || bus_a.output_cc_id !== 2'(w)) begin
        n_mismatched++;
        $display("FAIL not_match_out cc%0d: valid=%0b pc=%h cc=%0d, need 1 011 %0d",
                 w, bus_a.output_pc_valid, bus_a.output_pc, bus_a.output_cc_id, w);
      end
      pop_output();
    end
    set_char(2, 8'h61);
    bus_a.end_of_string = 4'b1000;
    for (int w = 2; w < 4; w++) begin
      send(9'h010, 2'(w));
      seen = 0;
      repeat (8) begin
        if (bus_a.output_pc_valid) seen = 1;
        @(negedge clk);
      end
      n_compared++;
      if (seen || bus_a.input_pc_ready !== 1'b1 || bus_a.busy !== 1'b0) begin
        n_mismatched++;
        $display("FAIL not_match_drop cc%0d: out_seen=%0b ready=%0b busy=%0b, need 0 1 0",
                 w, seen, bus_a.input_pc_ready, bus_a.busy);
      end
    end
    bus_a.end_of_string = 4'b0000;
  endtask

  task automatic test_split();
    int lat;
    prog[9'h1FF] = enc(OP_SPLIT, 13'h100);
    send(9'h1FF, 2'd3);
    wait_out_valid(lat);
    n_compared++;
    if (bus_a.output_pc_valid !== 1'b1 || bus_a.output_pc !== 9'h000 || bus_a.output_cc_id !== 2'd3) begin
      n_mismatched++;
      $display("FAIL split_first: valid=%0b pc=%h cc=%0d, need 1 000 3",
               bus_a.output_pc_valid, bus_a.output_pc, bus_a.output_cc_id);
    end
    pop_output();
    n_compared++;
    if (bus_a.output_pc_valid !== 1'b1 || bus_a.output_pc !== 9'h100 || bus_a.output_cc_id !== 2'd3) begin
      n_mismatched++;
      $display("FAIL split_second: valid=%0b pc=%h cc=%0d, need 1 100 3",
               bus_a.output_pc_valid, bus_a.output_pc, bus_a.output_cc_id);
    end
    pop_output();
    n_compared++;
    if (bus_a.busy !== 1'b0 || bus_a.output_pc_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL split_done: busy=%0b valid=%0b, need 0 0", bus_a.busy, bus_a.output_pc_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_pc [4] = '{9'h140, 9'h032, 9'h033, 9'h0AA};
    logic [1:0] exp_cc [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
    int ia = 0;
    int ib = 0;
    int n = 0;
    prog[9'h030] = enc(OP_JMP, 13'h140);
    prog[9'h031] = enc(OP_MATCH_ANY, 13'h0);
    prog[9'h032] = enc(OP_MATCH, 13'h78);
    prog[9'h033] = enc(OP_JMP, 13'h0AA);
    set_char(0, 8'h78);
    b_enable = 1'b1;
    bus_a.input_pc_valid = 1'b1;
    bus_a.input_cc_id    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      bus_a.input_pc = 9'h030 + 9'(i);
      n_compared++;
      if (bus_a.input_pc_ready !== 1'b1 || bus_b.input_pc_ready !== 1'b1) begin
        n_mismatched++;
        $display("FAIL b2b_ready_%0d: a=%0b b=%0b, need 1 1", i, bus_a.input_pc_ready, bus_b.input_pc_ready);
      end
      @(negedge clk);
    end
    bus_a.input_pc_valid = 1'b0;
    n_compared++;
    if (bus_a.input_pc_ready !== 1'b0 || bus_b.input_pc_ready !== 1'b0) begin
      n_mismatched++;
      $display("FAIL b2b_credit_full: a=%0b b=%0b, need 0 0", bus_a.input_pc_ready, bus_b.input_pc_ready);
    end
    repeat (10) @(negedge clk);
    n_compared++;
    if (bus_a.output_pc_valid !== 1'b1 || bus_a.output_pc !== 9'h140 || bus_a.input_pc_ready !== 1'b0) begin
      n_mismatched++;
      $display("FAIL b2b_hold: valid=%0b pc=%h ready=%0b, need 1 140 0",
               bus_a.output_pc_valid, bus_a.output_pc, bus_a.input_pc_ready);
    end
    bus_a.output_pc_ready = 1'b1;
    while ((ia < 4 || ib < 4) && n < 60) begin
      if (bus_a.output_pc_valid && ia < 4) begin
        n_compared++;
        if (bus_a.output_pc !== exp_pc[ia] || bus_a.output_cc_id !== exp_cc[ia]) begin
          n_mismatched++;
          $display("FAIL b2b_lat1_out%0d: pc=%h cc=%0d, need pc=%h cc=%0d",
                   ia, bus_a.output_pc, bus_a.output_cc_id, exp_pc[ia], exp_cc[ia]);
        end
        ia++;
      end
      if (bus_b.output_pc_valid && ib < 4) begin
        n_compared++;
        if (bus_b.output_pc !== exp_pc[ib] || bus_b.output_cc_id !== exp_cc[ib]) begin
          n_mismatched++;
          $display("FAIL b2b_lat3_out%0d: pc=%h cc=%0d, need pc=%h cc=%0d",
                   ib, bus_b.output_pc, bus_b.output_cc_id, exp_pc[ib], exp_cc[ib]);
        end
        ib++;
      end
      @(negedge clk);
      n++;
    end
    bus_a.output_pc_ready = 1'b0;
    b_enable = 1'b0;
    @(negedge clk);
    n_compared++;
    if (ia != 4 || ib != 4 || bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL b2b_complete: outs a=%0d b=%0d busy a=%0b b=%0b, need 4 4 0 0",
               ia, ib, bus_a.busy, bus_b.busy);
    end
  endtask

  task automatic test_accept();
    int pulses;
    logic [1:0] acc_cc;
    bit seen;
    logic [8:0] pcs [3] = '{9'h020, 9'h020, 9'h021};
    logic       eos2 [3] = '{1'b1, 1'b0, 1'b0};
    int         exp_p [3] = '{1, 0, 1};
    prog[9'h020] = enc(OP_ACCEPT, 13'h0);
    prog[9'h021] = enc(OP_ACCEPT_PARTIAL, 13'h0);
    for (int k = 0; k < 3; k++) begin
      bus_a.end_of_string = {1'b0, eos2[k], 2'b00};
      send(pcs[k], 2'd2);
      pulses = 0;
      acc_cc = 2'd0;
      seen   = 0;
      repeat (10) begin
        if (bus_a.accepts) begin
          pulses++;
          acc_cc = bus_a.accepts_cc_id;
        end
        if (bus_a.output_pc_valid) seen = 1;
        @(negedge clk);
      end
      n_compared++;
      if (pulses != exp_p[k] || (exp_p[k] == 1 && acc_cc !== 2'd2) || seen || bus_a.busy !== 1'b0) begin
        n_mismatched++;
        $display("FAIL accept_%0d: pulses=%0d cc=%0d out_seen=%0b busy=%0b, need %0d 2 0 0",
                 k, pulses, acc_cc, seen, bus_a.busy, exp_p[k]);
      end
    end
    bus_a.end_of_string = 4'b0000;
  endtask

  task automatic test_reset_mid_flight();
    int lat;
    bit seen;
    set_char(1, 8'h61);
    bus_a.input_pc_valid = 1'b1;
    bus_a.input_pc      = 9'h062;
    bus_a.input_cc_id   = 2'd1;
    repeat (3) @(negedge clk);
    bus_a.input_pc_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_compared++;
    if ({bus_a.input_pc_ready, bus_a.memory_valid, bus_a.memory_addr, bus_a.output_pc_valid,
         bus_a.output_pc, bus_a.output_cc_id, bus_a.accepts, bus_a.accepts_cc_id, bus_a.busy} !== '0) begin
      n_mismatched++;
      $display("FAIL midreset_outputs: ready=%0b mvalid=%0b addr=%h ovalid=%0b accepts_cc=%0d busy=%0b, need all 0",
               bus_a.input_pc_ready, bus_a.memory_valid, bus_a.memory_addr, bus_a.output_pc_valid,
               bus_a.accepts_cc_id, bus_a.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      if (bus_a.output_pc_valid || bus_a.busy) seen = 1;
      @(negedge clk);
    end
    n_compared++;
    if (seen || bus_a.input_pc_ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL midreset_late_data: activity=%0b ready=%0b, need 0 1", seen, bus_a.input_pc_ready);
    end
    send(9'h062, 2'd1);
    wait_out_valid(lat);
    n_compared++;
    if (lat != 4 || bus_a.output_pc !== 9'h063 || bus_a.output_cc_id !== 2'd2) begin
      n_mismatched++;
      $display("FAIL midreset_new_thread: lat=%0d pc=%h cc=%0d, need 4 063 2",
               lat, bus_a.output_pc, bus_a.output_cc_id);
    end
    pop_output();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) prog[i] = enc(OP_END_WITHOUT_ACCEPTING, 13'h0);
    bus_a.current_characters = '0;
    bus_a.end_of_string      = '0;
    bus_a.input_pc_valid     = 1'b0;
    bus_a.input_pc           = '0;
    bus_a.input_cc_id        = '0;
    bus_a.memory_ready       = 1'b1;
    bus_a.output_pc_ready    = 1'b0;
    test_reset();
    test_match();
    test_not_match();
    test_split();
    test_back_to_back();
    test_accept();
    test_reset_mid_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1);
  end
endmodule
